// File: rtl/module_adder_arbiter.sv
// module_adder_arbiter
//   Round-robin arbiter/sequencer sharing one external DATA_W-bit adder among
//   NUM_REQ requesters. A granted operand pair is registered onto the adder,
//   the sum is captured one cycle later and held, tagged with the requester
//   ID, until the consumer accepts it.
//
//   Optional feature macro: ADDER_ARB_CARRY_EN (adds rsp_carry_o).
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester grant (one-hot or zero)
//   req_a_i      flattened A operands, requester k at [k*DATA_W +: DATA_W]
//   req_b_i      flattened B operands, same packing
//   adder_a_o    registered A operand to the shared adder
//   adder_b_o    registered B operand to the shared adder
//   adder_y_i    combinational sum from the shared adder
//   rsp_valid_o  response valid
//   rsp_ready_i  response consumer ready
//   rsp_id_o     requester index owning the response
//   rsp_sum_o    captured sum
//   rsp_carry_o  carry out (only with ADDER_ARB_CARRY_EN)
module module_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [DATA_W-1:0]         adder_a_o,
  output logic [DATA_W-1:0]         adder_b_o,
  input  logic [DATA_W-1:0]         adder_y_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_sum_o
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic                      rsp_carry_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
`ifdef ADDER_ARB_CARRY_EN
  logic                carry_q, carry_d;
`endif

  logic                grant_en;
  logic                grant_any;
  logic                transfer;
  logic [ID_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;

  // Grants are only offered when the adder slot is free: IDLE, or RESP with
  // the held result being accepted this cycle. Reset suppresses grants.
  always_comb begin
    grant_en = !rst_i && ((state_q == ST_IDLE) ||
                          ((state_q == ST_RESP) && rsp_ready_i));
  end

  // Round-robin search starting one past the last winner. Shifts are used
  // instead of variable part-selects so the index width never matters.
  always_comb begin
    int unsigned         cand;
    logic [NUM_REQ-1:0]  vshift;
    grant_any = 1'b0;
    grant_idx = '0;
    a_sel     = '0;
    b_sel     = '0;
    cand      = 0;
    vshift    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand   = (32'(last_grant_q) + i) % NUM_REQ;
      vshift = req_valid_i >> cand;
      if (!grant_any && vshift[0]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
        a_sel     = DATA_W'(req_a_i >> (cand * DATA_W));
        b_sel     = DATA_W'(req_b_i >> (cand * DATA_W));
      end
    end
  end

  assign transfer = grant_en && grant_any;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
`ifdef ADDER_ARB_CARRY_EN
      carry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef ADDER_ARB_CARRY_EN
      carry_q      <= carry_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (transfer) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (transfer)         state_d = ST_EXEC;
        else if (rsp_ready_i) state_d = ST_IDLE;
        else                  state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values. A back-to-back grant in RESP only happens with
  // rsp_ready_i high, so reloading the ID register never disturbs a held
  // response.
  always_comb begin
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef ADDER_ARB_CARRY_EN
    carry_d      = carry_q;
`endif
    if (transfer) begin
      a_d          = a_sel;
      b_d          = b_sel;
      id_d         = grant_idx;
      last_grant_d = grant_idx;
    end
    if (state_q == ST_EXEC) begin
      sum_d       = adder_y_i;
      rsp_valid_d = 1'b1;
`ifdef ADDER_ARB_CARRY_EN
      // A wrapped sum is smaller than either operand.
      carry_d     = (adder_y_i < a_q);
`endif
    end else if ((state_q == ST_RESP) && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    req_ready_o = '0;
    if (transfer) req_ready_o = NUM_REQ'(1) << grant_idx;
  end

  assign adder_a_o   = a_q;
  assign adder_b_o   = b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_sum_o   = sum_q;
`ifdef ADDER_ARB_CARRY_EN
  assign rsp_carry_o = carry_q;
`endif

endmodule

// File: tb/tb_module_adder_arbiter.sv
module tb_module_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         opa [NUM_REQ];
  logic [DATA_W-1:0]         opb [NUM_REQ];
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0]         adder_a, adder_b, adder_y, rsp_sum;
  logic                      rsp_valid, rsp_ready;
  logic [ID_W-1:0]           rsp_id;
`ifdef ADDER_ARB_CARRY_EN
  logic                      rsp_carry;
`endif

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_a[k*DATA_W +: DATA_W] = opa[k];
      req_b[k*DATA_W +: DATA_W] = opb[k];
    end
  end

  // External shared adder
  assign adder_y = adder_a + adder_b;

  module_adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .adder_a_o   (adder_a),
    .adder_b_o   (adder_b),
    .adder_y_i   (adder_y),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum)
`ifdef ADDER_ARB_CARRY_EN
    ,
    .rsp_carry_o (rsp_carry)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: transaction view of the shared adder slot.
  int          ptr;           // last granted requester
  bit          exec_pending;  // operands on the adder this cycle
  bit          have_rsp;      // a result is waiting for the consumer
  int          ex_id, m_id;
  logic [31:0] ex_a, ex_b, m_sum;
  bit          m_carry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    if (rst || exec_pending || (have_rsp && !rsp_ready)) return -1;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = (ptr + i) % NUM_REQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_cycle(input int w);
    logic [NUM_REQ-1:0] exp_ready;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(have_rsp));
    if (have_rsp) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_sum", rsp_sum, m_sum);
`ifdef ADDER_ARB_CARRY_EN
      chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
`endif
    end
    chk("adder_a", adder_a, ex_a);
    chk("adder_b", adder_b, ex_b);
  endtask

  task automatic model_update(input int w);
    logic [32:0] full;
    if (exec_pending) begin
      full         = {1'b0, ex_a} + {1'b0, ex_b};
      have_rsp     = 1'b1;
      m_id         = ex_id;
      m_sum        = full[31:0];
      m_carry      = full[32];
      exec_pending = 1'b0;
    end else if (have_rsp && rsp_ready) begin
      have_rsp = 1'b0;
    end
    if (w >= 0) begin
      exec_pending = 1'b1;
      ex_id        = w;
      ex_a         = opa[w];
      ex_b         = opb[w];
      ptr          = w;
    end
  endtask

  // One clock: inputs already driven in the low phase.
  task automatic step(output int w, output logic [NUM_REQ-1:0] seen);
    #1;
    w    = model_winner();
    seen = req_ready;
    check_cycle(w);
    @(posedge clk);
    model_update(w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    exec_pending = 1'b0;
    have_rsp     = 1'b0;
    ptr          = NUM_REQ - 1;
    ex_id        = 0;
    ex_a         = '0;
    ex_b         = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_adder_a", adder_a, 32'h0);
    chk("rst_adder_b", adder_b, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_sum", rsp_sum, 32'h0);
`ifdef ADDER_ARB_CARRY_EN
    chk("rst_rsp_carry", 32'(rsp_carry), 32'h0);
`endif
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    int                 w;
    logic [NUM_REQ-1:0] seen;
    int                 exp_order [5];
    int                 n_grant;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    @(negedge clk);

    // Single request from requester 1
    do_reset();
    opa[1] = 32'd5; opb[1] = 32'd7; req_valid = 4'b0010; rsp_ready = 1'b0;
    #1 chk("single_grant", 32'(req_ready), 32'b0010);
    step(w, seen);
    req_valid = '0;
    step(w, seen);
    #1;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_id", 32'(rsp_id), 32'h1);
    chk("single_sum", rsp_sum, 32'd12);
    rsp_ready = 1'b1;
    step(w, seen);

    // All requesters continuously valid, consumer always ready
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      opa[k] = 32'(100 * (k + 1));
      opb[k] = 32'(k + 1);
    end
    req_valid = '1; rsp_ready = 1'b1;
    n_grant = 0;
    for (int c = 0; c < 10; c++) begin
      step(w, seen);
      if (seen != '0) begin
        if (n_grant < 5) chk("rr_order", 32'(onehot_idx(seen)), 32'(exp_order[n_grant]));
        n_grant++;
      end
    end
    chk("rr_count", 32'(n_grant), 32'd5);
    req_valid = '0;
    step(w, seen);
    step(w, seen);

    // Backpressure: held response blocks requester 2
    do_reset();
    opa[1] = 32'h1234; opb[1] = 32'h1111; req_valid = 4'b0010; rsp_ready = 1'b0;
    step(w, seen);
    req_valid = '0;
    step(w, seen);
    opa[2] = 32'hA0; opb[2] = 32'h0B; req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) step(w, seen);
    #1;
    chk("bp_hold_id", 32'(rsp_id), 32'h1);
    chk("bp_hold_sum", rsp_sum, 32'h2345);
    rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(req_ready), 32'b0100);
    step(w, seen);
    req_valid = '0;
    step(w, seen);
    step(w, seen);

    // Wrap-around
    do_reset();
    opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd2; req_valid = 4'b0001; rsp_ready = 1'b0;
    step(w, seen);
    req_valid = '0;
    step(w, seen);
    #1 chk("wrap_sum", rsp_sum, 32'd1);
`ifdef ADDER_ARB_CARRY_EN
    chk("wrap_carry", 32'(rsp_carry), 32'd1);
`endif
    rsp_ready = 1'b1;
    step(w, seen);

    // Reset while in EXEC
    do_reset();
    opa[2] = 32'd40; opb[2] = 32'd2; req_valid = 4'b0100; rsp_ready = 1'b1;
    step(w, seen);
    do_reset();
    for (int c = 0; c < 3; c++) step(w, seen);
    opa[3] = 32'd3; opb[3] = 32'd3; opa[0] = 32'd9; opb[0] = 32'd1;
    req_valid = 4'b1001;
    #1 chk("post_rst_grant", 32'(req_ready), 32'b0001);
    step(w, seen);
    req_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(w, seen);
      if (w >= 0) req_valid[w] = 1'b0;
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_valid[k] && $urandom_range(2) == 0) begin
          req_valid[k] = 1'b1;
          opa[k] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom();
          opb[k] = $urandom();
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      step(w, seen);
      if (w >= 0) req_valid[w] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
